// File: rtl/bcd_to_binary_seq_ctrl.sv
// Sequential multi-digit BCD-to-binary converter: reverse double-dabble, one step per clock,
// valid/ready on input and output, illegal digits reported instead of converted.
module bcd_to_binary_seq_ctrl #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      out_binary,
    output logic                  out_error,
    output logic                  busy
);

    localparam int SR_W  = 4*DIGITS + BIN_W;
    localparam int CNT_W = $clog2(BIN_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    logic [1:0]       r_state;
    logic [SR_W-1:0]  r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic [BIN_W-1:0] r_bin;
    logic             r_err;

    logic [SR_W-1:0]  w_shift;
    logic [SR_W-1:0]  w_step;
    logic             w_bad;

    // One reverse double-dabble step: shift, then pull every BCD digit that landed >= 8 back by 3.
    always_comb begin
        w_shift = r_sr >> 1;
        w_step  = w_shift;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (w_shift[BIN_W + 4*d + 3 -: 4] >= 4'd8)
                w_step[BIN_W + 4*d + 3 -: 4] = w_shift[BIN_W + 4*d + 3 -: 4] - 4'd3;
        end
    end

    always_comb begin
        w_bad = 1'b0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (in_bcd[4*d + 3 -: 4] > 4'd9)
                w_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_bin   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_bad) begin
                            r_bin   <= '0;
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_sr    <= {in_bcd, {BIN_W{1'b0}}};
                            r_cnt   <= '0;
                            r_state <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    r_sr  <= w_step;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_STEP) begin
                        r_bin   <= w_step[BIN_W-1:0];
                        r_err   <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result registers are left untouched so they keep their value after the handshake.
                    if (out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign out_binary = r_bin;
    assign out_error  = r_err;

endmodule

// File: tb/tb_bcd_to_binary_seq_ctrl.sv
// Self-checking bench for bcd_to_binary_seq_ctrl (DIGITS=4, BIN_W=14): vector table,
// hand-written handshake/reset sequences and random words against a decimal reference model.
module tb_bcd_to_binary_seq_ctrl;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_bcd;
    logic              out_valid;
    logic              out_ready;
    logic [BIN_W-1:0]  out_binary;
    logic              out_error;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bcd_to_binary_seq_ctrl #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bcd     (in_bcd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_binary (out_binary),
        .out_error  (out_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] bcd;
        int          exp_bin;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: the word's decimal value, digit by digit, or an error if any digit exceeds 9.
    task automatic model(input logic [15:0] bcd, output int val, output logic err);
        logic [15:0] w;
        int unsigned dig;
        w   = bcd;
        val = 0;
        err = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dig = 32'(w[4*i +: 4]);
            if (dig > 9) err = 1'b1;
            val = val * 10 + int'(dig);
        end
        if (err) val = 0;
    endtask

    // Waits for in_ready, presents one word for one edge, then counts cycles until out_valid.
    // lat counts the acceptance cycle, so a full conversion reads BIN_W+1 and an error reads 1.
    task automatic send(input logic [15:0] bcd, output int lat, output int acc_cyc);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_bcd   = bcd;
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        in_valid = 1'b0;
        in_bcd   = 16'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("inready_after_accept", 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take();
        logic [BIN_W-1:0] b;
        logic             e;
        b = out_binary;
        e = out_error;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("inready_back", 32'(in_ready), 32'd1);
        chk("bin_retained", 32'(out_binary), 32'(b));
        chk("err_retained", 32'(out_error), 32'(e));
    endtask

    task automatic run_checked(input string name, input logic [15:0] bcd);
        int   lat, acc, ev;
        logic ee;
        model(bcd, ev, ee);
        send(bcd, lat, acc);
        chk({name, "_lat"}, 32'(lat), ee ? 32'd1 : 32'(BIN_W + 1));
        chk({name, "_bin"}, 32'(out_binary), 32'(ev));
        chk({name, "_err"}, 32'(out_error), 32'(ee));
        take();
    endtask

    vec_t vecs[$];

    initial begin
        int lat, acc0, acc1, acc2, ev;
        logic ee;
        logic [15:0] w;

        vecs.push_back('{16'h0000,    0, 1'b0});
        vecs.push_back('{16'h9999, 9999, 1'b0});
        vecs.push_back('{16'h0001,    1, 1'b0});
        vecs.push_back('{16'h0010,   10, 1'b0});
        vecs.push_back('{16'h9000, 9000, 1'b0});
        vecs.push_back('{16'h0808,  808, 1'b0});
        vecs.push_back('{16'h12A4,    0, 1'b1});
        vecs.push_back('{16'h5555, 5555, 1'b0});
        vecs.push_back('{16'hF000,    0, 1'b1});
        vecs.push_back('{16'h000A,    0, 1'b1});
        vecs.push_back('{16'h1234, 1234, 1'b0});

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_bcd    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_binary", 32'(out_binary), 32'd0);
        chk("rst_out_error", 32'(out_error), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            send(vecs[i].bcd, lat, acc0);
            chk("vec_lat", 32'(lat), vecs[i].exp_err ? 32'd1 : 32'(BIN_W + 1));
            chk("vec_bin", 32'(out_binary), 32'(vecs[i].exp_bin));
            chk("vec_err", 32'(out_error), 32'(vecs[i].exp_err));
            take();
        end

        // Back-to-back words: each accept lands BIN_W+2 cycles after the previous one.
        send(16'h0063, lat, acc0);
        chk("b2b_63", 32'(out_binary), 32'd63);
        take();
        send(16'h0029, lat, acc1);
        chk("b2b_29", 32'(out_binary), 32'd29);
        take();
        send(16'h1234, lat, acc2);
        chk("b2b_1234", 32'(out_binary), 32'd1234);
        take();
        chk("b2b_gap1", 32'(acc1 - acc0), 32'(BIN_W + 2));
        chk("b2b_gap2", 32'(acc2 - acc1), 32'(BIN_W + 2));

        // Result held in DONE with out_ready low; in_valid pulses meanwhile must be ignored.
        send(16'h0058, lat, acc0);
        chk("hold_lat", 32'(lat), 32'(BIN_W + 1));
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            in_bcd   = 16'h0777;
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_bin", 32'(out_binary), 32'd58);
        end
        in_valid = 1'b0;
        take();
        chk("hold_no_capture", 32'(busy), 32'd0);
        run_checked("after_hold", 16'h0307);

        // Reset mid-conversion abandons the word.
        send(16'h4567, lat, acc0);
        chk("pre_reset_bin", 32'(out_binary), 32'd4567);
        take();
        in_valid = 1'b1;
        in_bcd   = 16'h4567;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_binary", 32'(out_binary), 32'd0);
        chk("midrst_out_error", 32'(out_error), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_result", 32'(out_valid), 32'd0);
        run_checked("post_reset", 16'h0024);

        // Random words, with an occasional illegal digit.
        for (int n = 0; n < 40; n++) begin
            w = '0;
            for (int d = 0; d < DIGITS; d++)
                w[4*d +: 4] = 4'($urandom_range(9));
            if ($urandom_range(9) == 0)
                w[4*$urandom_range(DIGITS - 1) +: 4] = 4'($urandom_range(15, 10));
            model(w, ev, ee);
            send(w, lat, acc0);
            chk("rnd_lat", 32'(lat), ee ? 32'd1 : 32'(BIN_W + 1));
            chk("rnd_bin", 32'(out_binary), 32'(ev));
            chk("rnd_err", 32'(out_error), 32'(ee));
            take();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
